// File: rtl/sysctrl_gen.sv
// sysctrl_gen: MCU byte-protocol system-control endpoint.
// LEDs, colour, config slots, interrupts, menu streaming and read-back.
module sysctrl_gen #(
  parameter logic [7:0]           CORE_ID      = 8'h00,
  parameter int                   NUM_CFG      = 24,
  parameter logic [8*NUM_CFG-1:0] CFG_IDS      = {NUM_CFG{8'h00}},
  parameter logic [8*NUM_CFG-1:0] CFG_DEFAULTS = {NUM_CFG{8'h00}},
  parameter int                   NUM_BTN      = 2,
  parameter int                   NUM_INT      = 8,
  parameter int                   MENU_AW      = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_in_strobe,
  input  logic                 data_in_start,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 int_out_n,
  input  logic [NUM_INT-1:0]   int_in,
  output logic [NUM_INT-1:0]   int_ack,
  input  logic [NUM_BTN-1:0]   buttons,
  output logic [1:0]           leds,
  output logic [23:0]          color,
  output logic [MENU_AW-1:0]   menu_addr,
  input  logic [7:0]           menu_data,
  output logic [8*NUM_CFG-1:0] cfg_values,
  output logic [NUM_CFG-1:0]   cfg_update
);

  localparam logic [7:0] CMD_NOP = 8'hFF;

  logic [7:0]           cmd_q, cmd_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           id_q, id_d;
  logic [7:0]           dout_d;
  logic [1:0]           leds_d;
  logic [23:0]          color_d;
  logic [NUM_INT-1:0]   ack_d;
  logic [8*NUM_CFG-1:0] cfg_d;
  logic [NUM_CFG-1:0]   upd_d;
  logic [MENU_AW-1:0]   addr_d;
  logic                 rearm;
  logic                 clr_cold;

  logic                 sys_int;
  logic                 coldboot;
  logic                 btn_armed;
  logic [NUM_BTN-1:0]   btn_meta;
  logic [NUM_BTN-1:0]   btn_sync;
  logic                 btn_evt;

  logic [NUM_CFG-1:0]   hit_mask;
  logic                 hit;
  logic [7:0]           hit_val;
  logic [NUM_INT-1:0]   irq_vec;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  // Walk downward so the lowest matching slot wins.
  always_comb begin
    hit_mask = '0;
    hit      = 1'b0;
    hit_val  = 8'hFF;
    for (int i = NUM_CFG - 1; i >= 0; i--) begin
      if (CFG_IDS[8*i +: 8] == id_q) begin
        hit_mask = NUM_CFG'(1) << i;
        hit      = 1'b1;
        hit_val  = cfg_values[8*i +: 8];
      end
    end
  end

  assign irq_vec   = (int_in & ~NUM_INT'(1)) | NUM_INT'(sys_int);
  assign int_out_n = ~(|irq_vec);
  assign btn_evt   = btn_armed && (btn_meta != btn_sync);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= CMD_NOP;
      cnt_q      <= '0;
      id_q       <= '0;
      data_out   <= '0;
      leds       <= '0;
      color      <= '0;
      int_ack    <= '0;
      cfg_values <= CFG_DEFAULTS;
      cfg_update <= '0;
      menu_addr  <= '0;
    end else begin
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      data_out   <= dout_d;
      leds       <= leds_d;
      color      <= color_d;
      int_ack    <= ack_d;
      cfg_values <= cfg_d;
      cfg_update <= upd_d;
      menu_addr  <= addr_d;
    end
  end

  always_comb begin
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    dout_d   = data_out;
    leds_d   = leds;
    color_d  = color;
    ack_d    = '0;
    cfg_d    = cfg_values;
    upd_d    = '0;
    addr_d   = menu_addr;
    rearm    = 1'b0;
    clr_cold = 1'b0;
    if (data_in_strobe && data_in_start) begin
      cmd_d  = data_in;
      cnt_d  = '0;
      dout_d = '0;
      addr_d = '0;
    end else if (data_in_strobe && cmd_q != CMD_NOP) begin
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      unique case (1'b1)
        cmd_q == 8'h00: begin
          case (cnt_q)
            4'd0:    dout_d = 8'h5C;
            4'd1:    dout_d = 8'h42;
            4'd2:    dout_d = CORE_ID;
            default: dout_d = 8'h00;
          endcase
        end
        cmd_q == 8'h01: begin
          if (cnt_q == 4'd0) leds_d = data_in[1:0];
        end
        cmd_q == 8'h02: begin
          case (cnt_q)
            4'd0:    color_d[15:8]  = rev8(data_in);
            4'd1:    color_d[7:0]   = rev8(data_in);
            4'd2:    color_d[23:16] = rev8(data_in);
            default: ;
          endcase
        end
        cmd_q == 8'h03: begin
          dout_d = 8'(buttons);
          rearm  = 1'b1;
        end
        cmd_q == 8'h04: begin
          if (cnt_q == 4'd0) begin
            id_d = data_in;
          end else if (cnt_q == 4'd1) begin
            upd_d = hit_mask;
            for (int i = 0; i < NUM_CFG; i++)
              if (hit_mask[i]) cfg_d[8*i +: 8] = data_in;
          end
        end
        cmd_q == 8'h05: begin
          if (cnt_q == 4'd0) ack_d = data_in[NUM_INT-1:0];
          dout_d = 8'(irq_vec);
        end
        cmd_q == 8'h06: begin
          dout_d   = {5'b0, ~btn_armed, 1'b0, coldboot};
          clr_cold = (cnt_q == 4'd0);
        end
        cmd_q == 8'h08: begin
          dout_d = menu_data;
          addr_d = menu_addr + MENU_AW'(1);
        end
        cmd_q == 8'h09: begin
          if (cnt_q == 4'd0) begin
            id_d   = data_in;
            dout_d = 8'h00;
          end else if (cnt_q == 4'd1) begin
            dout_d = hit ? hit_val : 8'hFF;
          end else begin
            dout_d = 8'h00;
          end
        end
        default: dout_d = 8'h00;
      endcase
    end
  end

  // Button event and interrupt latch; a new event beats a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_armed <= 1'b1;
      sys_int   <= 1'b1;
      coldboot  <= 1'b1;
    end else begin
      btn_meta  <= buttons;
      btn_sync  <= btn_meta;
      btn_armed <= (btn_armed & ~btn_evt) | rearm;
      sys_int   <= btn_evt | (sys_int & ~int_ack[0]);
      coldboot  <= coldboot & ~clr_cold;
    end
  end

endmodule
